// File: rtl/fir_filter_mac.sv
// Time-multiplexed single-MAC FIR filter with a runtime-loadable coefficient RAM.
// Define FIR_SAT_EN to clamp the output to the DATA_W range and add the sat_flag port.
module fir_filter_mac #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 18,
    parameter int TAPS      = 128,
    parameter int OUT_SHIFT = 18,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_valid
`ifdef FIR_SAT_EN
    ,
    output logic                      sat_flag
`endif
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST_IDX   = AW'(TAPS - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'd2;

    typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, DONE} state_t;
    state_t state_reg, state_next;

    logic signed [COEF_W-1:0] coef_mem  [TAPS];
    logic signed [DATA_W-1:0] delay_mem [TAPS];

    logic [1:0]               run_reg;
    logic [AW-1:0]            clr_idx_reg, wp_reg, rd_ptr_reg, tap_reg;
    logic [1:0]               drain_cnt_reg;
    logic signed [COEF_W-1:0] coef_q_reg;
    logic signed [DATA_W-1:0] data_q_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic                     rd_vld_reg, mul_vld_reg;
    logic signed [ACC_W-1:0]  acc_reg;

    logic                     accept, coef_wr, clr_step, addr_ok;
    logic signed [PROD_W-1:0] data_ext, coef_ext;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [DATA_W-1:0] result;
    logic                     clamp;

    // Out-of-range addresses only exist when TAPS is not a power of two.
    generate
        if (TAPS == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = (coef_addr <= LAST_IDX);
        end
    endgenerate

    assign in_ready = (state_reg == IDLE);
    assign accept   = in_ready && in_valid;
    assign coef_wr  = in_ready && coef_we && addr_ok;
    assign clr_step = (state_reg == CLEAR) && run_reg[1];

    assign data_ext = $signed({{COEF_W{data_q_reg[DATA_W-1]}}, data_q_reg});
    assign coef_ext = $signed({{DATA_W{coef_q_reg[COEF_W-1]}}, coef_q_reg});
    assign prod_ext = $signed({{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg});

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_reg >>> OUT_SHIFT;
        result  = shifted[DATA_W-1:0];
        clamp   = 1'b0;
        if (shifted > MAX_V) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
            clamp  = 1'b1;
        end else if (shifted < MIN_V) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
            clamp  = 1'b1;
        end
    end
`else
    always_comb begin
        result = DATA_W'(acc_reg >>> OUT_SHIFT);
        clamp  = 1'b0;
    end
`endif

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            CLEAR:   if (clr_step && clr_idx_reg == LAST_IDX) state_next = IDLE;
            IDLE:    if (in_valid) state_next = MAC;
            MAC:     if (tap_reg == LAST_IDX) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg == DRAIN_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // Storage and the read/multiply pipeline stages carry no reset so they map onto RAM/DSP.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            delay_mem[clr_idx_reg] <= '0;
            coef_mem[clr_idx_reg]  <= '0;
        end else begin
            if (accept)  delay_mem[wp_reg]  <= in_data;
            if (coef_wr) coef_mem[coef_addr] <= coef_data;
        end
        coef_q_reg <= coef_mem[tap_reg];
        data_q_reg <= delay_mem[rd_ptr_reg];
        prod_reg   <= data_ext * coef_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg       <= '0;
            state_reg     <= CLEAR;
            clr_idx_reg   <= '0;
            wp_reg        <= '0;
            rd_ptr_reg    <= '0;
            tap_reg       <= '0;
            drain_cnt_reg <= '0;
            rd_vld_reg    <= 1'b0;
            mul_vld_reg   <= 1'b0;
            acc_reg       <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
`ifdef FIR_SAT_EN
            sat_flag      <= 1'b0;
`endif
        end else begin
            // Reset release is re-timed here before CLEAR starts stepping.
            run_reg     <= {run_reg[0], 1'b1};
            state_reg   <= state_next;
            out_valid   <= 1'b0;
            rd_vld_reg  <= (state_reg == MAC);
            mul_vld_reg <= rd_vld_reg;

            if (clr_step)
                clr_idx_reg <= (clr_idx_reg == LAST_IDX) ? '0 : clr_idx_reg + 1'b1;

            if (accept) begin
                wp_reg     <= (wp_reg == LAST_IDX) ? '0 : wp_reg + 1'b1;
                rd_ptr_reg <= wp_reg;
                tap_reg    <= '0;
                acc_reg    <= '0;
            end

            if (state_reg == MAC) begin
                tap_reg    <= tap_reg + 1'b1;
                rd_ptr_reg <= (rd_ptr_reg == '0) ? LAST_IDX : rd_ptr_reg - 1'b1;
            end

            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 2'd1 : 2'd0;

            if (mul_vld_reg) acc_reg <= acc_reg + prod_ext;

            if (state_reg == DONE) begin
                out_data  <= result;
                out_valid <= 1'b1;
`ifdef FIR_SAT_EN
                sat_flag  <= clamp;
`endif
            end
        end
    end

`ifndef FIR_SAT_EN
    logic unused_clamp;
    assign unused_clamp = clamp;
`endif

endmodule

// File: tb/tb_fir_filter_mac.sv
// Scoreboard bench for fir_filter_mac (TAPS=8, 16-bit data and coefficients, no output shift).
module tb_fir_filter_mac;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 8;
    localparam int LAT  = TAPS + 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 coef_we = 1'b0;
    logic [2:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
`ifdef FIR_SAT_EN
    logic                 sat_flag;
`endif

    typedef struct {
        logic signed [DW-1:0] d;
        bit                   chk;
        bit                   sat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   chk_period = 1'b0;

    fir_filter_mac #(
        .DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_SHIFT(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_data(out_data),
        .out_valid(out_valid)
`ifdef FIR_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coef(input int k, input int v);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (!in_ready) check("coef_ready_timeout", 0, 1);
        coef_we   = 1'b1;
        coef_addr = 3'(k);
        coef_data = CW'(v);
        tick();
        coef_we   = 1'b0;
        $display("[TB] coef c[%0d] = %0d", k, v);
    endtask

    task automatic send(input int x, input int e, input bit chk, input bit sat, input bit push);
        int   n = 0;
        exp_t ex;
        in_data  = DW'(x);
        in_valid = 1'b1;
        if (push) begin
            ex.d = DW'(e); ex.chk = chk; ex.sat = sat;
            exp_q.push_back(ex);
        end
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) check("send_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: logs accepts, checks period when enabled, pops and compares each output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc + 1);
                if (chk_period && last_acc >= 0) check("accept_period", cyc + 1 - last_acc, TAPS + 5);
                last_acc = cyc + 1;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t ex;
                    int   t;
                    ex = exp_q.pop_front();
                    t  = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    check("latency", cyc - t, LAT);
                    if (ex.chk) check("out_data", out_data, ex.d);
`ifdef FIR_SAT_EN
                    if (ex.chk) check("sat_flag", sat_flag, ex.sat);
`endif
                    $display("[TB] out %0d expected %0d%s at cycle %0d", out_data, ex.d,
                             ex.chk ? "" : " (unchecked)", cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3 rst_n = 1'b0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("clear_min_len", n >= TAPS, 1);
        check("ready_after_clear", in_ready, 1);

        // 1: impulse response
        for (int k = 0; k < TAPS; k++) set_coef(k, k + 1);
        send(1, 1, 1, 0, 1);
        for (int j = 2; j <= TAPS; j++) send(0, j, 1, 0, 1);
        send(0, 0, 1, 0, 1);
        drain();

        // 2: step response
        for (int k = 0; k < TAPS; k++) set_coef(k, 3);
        for (int j = 1; j <= 10; j++) send(5, 15 * ((j < TAPS) ? j : TAPS), 1, 0, 1);
        drain();

        // 3: signed arithmetic
        set_coef(0, -2);
        for (int k = 1; k < TAPS; k++) set_coef(k, 0);
        send(-7, 14, 1, 0, 1);
        send(7, -14, 1, 0, 1);
        drain();

        // 4: overflow on the 8th output
        for (int k = 0; k < TAPS; k++) set_coef(k, 32767);
        for (int j = 1; j < TAPS; j++) send(32767, 0, 0, 0, 1);
`ifdef FIR_SAT_EN
        send(32767, 32767, 1, 1, 1);
`else
        send(32767, 8, 1, 0, 1);
`endif
        drain();

        // 5: continuous in_valid, then a coefficient write during MAC
        for (int k = 0; k < TAPS; k++) set_coef(k, k + 1);
        last_acc   = -1;
        chk_period = 1'b1;
        for (int j = 0; j < TAPS; j++) send(0, 0, 0, 0, 1);
        send(3, 3, 1, 0, 1);
        send(0, 6, 1, 0, 1);
        send(0, 9, 1, 0, 1);
        send(1, 13, 1, 0, 1);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd100;
        tick();
        coef_we = 1'b0;
        send(0, 17, 1, 0, 1);
        drain();
        chk_period = 1'b0;

        // 6: reset during MAC, then the impulse must repeat exactly
        send(1, 0, 0, 0, 0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        tick();
        check("midrst_out_data", out_data, 0);
        acc_q.delete();
        rst_n = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("midrst_clear_min", n >= TAPS, 1);
        check("midrst_clear_max", n <= TAPS + 4, 1);
        for (int k = 0; k < TAPS; k++) set_coef(k, k + 1);
        send(1, 1, 1, 0, 1);
        for (int j = 2; j <= TAPS; j++) send(0, j, 1, 0, 1);
        send(0, 0, 1, 0, 1);
        drain();
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
